// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its monitor:
// lamp bit positions, the intersection phase encoding and the fault codes.
package traffic_pkg;

  localparam int unsigned LAMP_W  = 3;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned SEC_W   = 8;

  // Bit positions inside one lamp vector
  localparam int unsigned LAMP_R = 2;
  localparam int unsigned LAMP_Y = 1;
  localparam int unsigned LAMP_G = 0;

  typedef enum logic [PHASE_W-1:0] {
    PH_SYNC      = 3'd0,
    PH_ALL_RED   = 3'd1,
    PH_NS_GREEN  = 3'd2,
    PH_NS_YELLOW = 3'd3,
    PH_EW_GREEN  = 3'd4,
    PH_EW_YELLOW = 3'd5,
    PH_FAULT     = 3'd7
  } phase_e;

  localparam logic [CODE_W-1:0] FLT_NONE        = 3'd0;
  localparam logic [CODE_W-1:0] FLT_ENCODING    = 3'd1;
  localparam logic [CODE_W-1:0] FLT_CONFLICT    = 3'd2;
  localparam logic [CODE_W-1:0] FLT_SEQUENCE    = 3'd3;
  localparam logic [CODE_W-1:0] FLT_YELLOW_TIME = 3'd4;
  localparam logic [CODE_W-1:0] FLT_SHORT_GREEN = 3'd5;
  localparam logic [CODE_W-1:0] FLT_TIMEOUT     = 3'd6;

  // One sample of both approach lamps
  typedef struct packed {
    logic [LAMP_W-1:0] ns;
    logic [LAMP_W-1:0] ew;
  } lamp_pair_t;

  // A lamp is well formed when exactly one of its bulbs is lit
  function automatic logic one_hot(input logic [LAMP_W-1:0] lamp);
    return ($countones(lamp) == 1);
  endfunction

  // Map a well-formed, conflict-free lamp pair to its phase; anything else maps to SYNC
  function automatic phase_e decode_phase(input logic [LAMP_W-1:0] ns,
                                          input logic [LAMP_W-1:0] ew);
    phase_e p;
    p = PH_SYNC;
    if (ns[LAMP_R] && ew[LAMP_R])      p = PH_ALL_RED;
    else if (ns[LAMP_G] && ew[LAMP_R]) p = PH_NS_GREEN;
    else if (ns[LAMP_Y] && ew[LAMP_R]) p = PH_NS_YELLOW;
    else if (ns[LAMP_R] && ew[LAMP_G]) p = PH_EW_GREEN;
    else if (ns[LAMP_R] && ew[LAMP_Y]) p = PH_EW_YELLOW;
    return p;
  endfunction

  function automatic logic is_green(input phase_e p);
    return (p == PH_NS_GREEN) || (p == PH_EW_GREEN);
  endfunction

  function automatic logic is_yellow(input phase_e p);
    return (p == PH_NS_YELLOW) || (p == PH_EW_YELLOW);
  endfunction

  // Allowed phase-to-phase steps of a healthy controller
  function automatic logic legal_step(input phase_e from, input phase_e to);
    logic ok;
    case (from)
      PH_ALL_RED:   ok = (to == PH_NS_GREEN) || (to == PH_EW_GREEN);
      PH_NS_GREEN:  ok = (to == PH_NS_YELLOW);
      PH_NS_YELLOW: ok = (to == PH_ALL_RED) || (to == PH_EW_GREEN);
      PH_EW_GREEN:  ok = (to == PH_EW_YELLOW);
      PH_EW_YELLOW: ok = (to == PH_ALL_RED) || (to == PH_NS_GREEN);
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs, 1 Hz strobe, fault clear and monitor status outputs.
// master = traffic controller side, slave = monitor side.
interface traffic_light_monitor_if;
  import traffic_pkg::*;

  logic                tick;
  logic [LAMP_W-1:0]   light_ns;
  logic [LAMP_W-1:0]   light_ew;
  logic                clear_fault;
  logic                fault;
  logic [CODE_W-1:0]   fault_code;
  logic [PHASE_W-1:0]  phase;
  logic [SEC_W-1:0]    phase_sec;
  logic [SEC_W-1:0]    last_phase_sec;

  modport master (
    output tick, light_ns, light_ew, clear_fault,
    input  fault, fault_code, phase, phase_sec, last_phase_sec
  );

  modport slave (
    input  tick, light_ns, light_ew, clear_fault,
    output fault, fault_code, phase, phase_sec, last_phase_sec
  );

endinterface

// File: rtl/phase_timer.sv
// Saturating seconds-in-phase counter. clear restarts the count at zero and
// captures the finished duration; hold freezes the count.
module phase_timer
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             hold,
  input  logic             tick,
  output logic [SEC_W-1:0] phase_sec,
  output logic [SEC_W-1:0] last_phase_sec
);

  localparam logic [SEC_W-1:0] SEC_MAX = '1;

  // Count ticks; clear beats a coincident tick so a new phase starts at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_sec      <= '0;
      last_phase_sec <= '0;
    end else if (clear) begin
      last_phase_sec <= phase_sec;
      phase_sec      <= '0;
    end else if (tick && !hold && (phase_sec != SEC_MAX)) begin
      phase_sec <= phase_sec + SEC_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Checks the traffic controller's lamp outputs: registers them, decodes the
// intersection phase, enforces sequence / conflict / duration rules and
// latches the first violation as a sticky fault code.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned MAX_PHASE   = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  traffic_light_monitor_if.slave mon
);

  lamp_pair_t         lamps_q;
  logic               tick_q;
  logic               clear_q;

  phase_e             state;
  phase_e             state_next;
  phase_e             observed;
  logic               fault_q;
  logic [CODE_W-1:0]  code_q;
  logic [CODE_W-1:0]  code_next;
  logic [CODE_W-1:0]  violation;

  logic               dark;
  logic               enc_err;
  logic               conf_err;
  logic               changed;
  logic               timer_clear;
  logic               timer_hold;
  logic [SEC_W-1:0]   phase_sec;
  logic [SEC_W-1:0]   last_sec;

  // Single input register stage; every check works on these copies
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lamps_q <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      lamps_q.ns <= mon.light_ns;
      lamps_q.ew <= mon.light_ew;
      tick_q     <= mon.tick;
      clear_q    <= mon.clear_fault;
    end
  end

  // Lamp legality and phase decode of the registered pair
  always_comb begin
    dark     = (lamps_q.ns == '0) && (lamps_q.ew == '0);
    enc_err  = !one_hot(lamps_q.ns) || !one_hot(lamps_q.ew);
    conf_err = !lamps_q.ns[LAMP_R] && !lamps_q.ew[LAMP_R];
    observed = decode_phase(lamps_q.ns, lamps_q.ew);
  end

  // Next state, fault selection (lowest code wins) and timer control.
  // SYNC and the clear request skip the all-dark pattern, which is what the
  // input register holds straight out of reset.
  always_comb begin
    state_next  = state;
    code_next   = code_q;
    violation   = FLT_NONE;
    timer_clear = 1'b0;
    timer_hold  = 1'b0;
    changed     = (observed != state);

    case (state)
      PH_FAULT: begin
        timer_hold = 1'b1;
        if (clear_q) begin
          if (!dark && enc_err)       violation = FLT_ENCODING;
          else if (!dark && conf_err) violation = FLT_CONFLICT;
          if (violation != FLT_NONE) begin
            code_next = violation;
          end else begin
            state_next  = PH_SYNC;
            code_next   = FLT_NONE;
            timer_clear = 1'b1;
          end
        end
      end

      PH_SYNC: begin
        timer_hold = 1'b1;
        if (!dark) begin
          if (enc_err)       violation = FLT_ENCODING;
          else if (conf_err) violation = FLT_CONFLICT;
          if (violation != FLT_NONE) begin
            state_next = PH_FAULT;
            code_next  = violation;
          end else begin
            state_next  = observed;
            timer_clear = 1'b1;
          end
        end
      end

      default: begin
        if (enc_err)
          violation = FLT_ENCODING;
        else if (conf_err)
          violation = FLT_CONFLICT;
        else if (changed && !legal_step(state, observed))
          violation = FLT_SEQUENCE;
        else if (changed && is_yellow(state) && (phase_sec != SEC_W'(YELLOW_TIME)))
          violation = FLT_YELLOW_TIME;
        else if (changed && is_green(state) && (phase_sec < SEC_W'(MIN_GREEN)))
          violation = FLT_SHORT_GREEN;
        else if (phase_sec > SEC_W'(MAX_PHASE))
          violation = FLT_TIMEOUT;

        if (violation != FLT_NONE) begin
          state_next = PH_FAULT;
          code_next  = violation;
          timer_hold = 1'b1;
        end else if (changed) begin
          state_next  = observed;
          timer_clear = 1'b1;
        end
      end
    endcase
  end

  // State register and fault latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= PH_SYNC;
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
    end else begin
      state   <= state_next;
      fault_q <= (state_next == PH_FAULT);
      code_q  <= code_next;
    end
  end

  phase_timer u_timer (
    .clk            (clk),
    .reset          (reset),
    .clear          (timer_clear),
    .hold           (timer_hold),
    .tick           (tick_q),
    .phase_sec      (phase_sec),
    .last_phase_sec (last_sec)
  );

  assign mon.fault          = fault_q;
  assign mon.fault_code     = code_q;
  assign mon.phase          = PHASE_W'(state);
  assign mon.phase_sec      = phase_sec;
  assign mon.last_phase_sec = last_sec;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scenario bench for traffic_light_monitor: expected status words are queued
// as stimulus is driven and popped when the monitor output is sampled.
module tb_traffic_light_monitor;

  typedef struct packed {
    logic       fault;
    logic [2:0] code;
    logic [2:0] phase;
    logic [7:0] sec;
    logic [7:0] last;
  } status_t;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] DARK = 3'b000;

  localparam logic [2:0] P_SYNC = 3'd0;
  localparam logic [2:0] P_AR   = 3'd1;
  localparam logic [2:0] P_NSG  = 3'd2;
  localparam logic [2:0] P_NSY  = 3'd3;
  localparam logic [2:0] P_EWG  = 3'd4;
  localparam logic [2:0] P_EWY  = 3'd5;
  localparam logic [2:0] P_FLT  = 3'd7;

  logic clk = 1'b0;
  logic reset;

  traffic_light_monitor_if bus ();

  traffic_light_monitor #(
    .MIN_GREEN   (5),
    .YELLOW_TIME (2),
    .MAX_PHASE   (30)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  always #5 clk = ~clk;

  status_t exp_q[$];
  string   name_q[$];
  int      n_vec = 0;
  int      n_err = 0;
  status_t got;
  status_t want;
  string   nm;

  logic [2:0] lc_ns  [4] = '{G, Y, R, R};
  logic [2:0] lc_ew  [4] = '{R, R, G, Y};
  logic [2:0] lc_ph  [4] = '{P_NSG, P_NSY, P_EWG, P_EWY};
  int         lc_dur [4] = '{5, 2, 5, 2};

  function automatic status_t mk(input logic f, input logic [2:0] c, input logic [2:0] p,
                                 input int s, input int l);
    status_t r;
    r.fault = f;
    r.code  = c;
    r.phase = p;
    r.sec   = 8'(s);
    r.last  = 8'(l);
    return r;
  endfunction

  function automatic status_t sample();
    status_t r;
    r.fault = bus.fault;
    r.code  = bus.fault_code;
    r.phase = bus.phase;
    r.sec   = bus.phase_sec;
    r.last  = bus.last_phase_sec;
    return r;
  endfunction

  function automatic string fmt(input status_t s);
    return $sformatf("fault=%0b code=%0d phase=%0d sec=%0d last=%0d",
                     s.fault, s.code, s.phase, s.sec, s.last);
  endfunction

  function automatic void expect_status(input string n, input status_t s);
    name_q.push_back(n);
    exp_q.push_back(s);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a lamp pair and hold it for a number of 1 Hz ticks
  task automatic hold(input logic [2:0] ns, input logic [2:0] ew, input int secs);
    bus.light_ns = ns;
    bus.light_ew = ew;
    cyc(2);
    for (int s = 0; s < secs; s++) begin
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
      cyc(3);
    end
  endtask

  // Pulse clear_fault with a legal ALL_RED on the lamps
  task automatic clear_all_red();
    bus.light_ns    = R;
    bus.light_ew    = R;
    bus.clear_fault = 1'b1;
    cyc(1);
    bus.clear_fault = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    bus.light_ns    = DARK;
    bus.light_ew    = DARK;
    bus.tick        = 1'b0;
    bus.clear_fault = 1'b0;
    expect_status("reset_values", mk(0, 3'd0, P_SYNC, 0, 0));
    cyc(3);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    reset = 1'b0;
    expect_status("dark_after_reset", mk(0, 3'd0, P_SYNC, 0, 0));
    cyc(3);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_legal_cycle();
    int last_m;
    last_m = 0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) begin
        expect_status($sformatf("legal_r%0d_p%0d", rep, i), mk(0, 3'd0, lc_ph[i], lc_dur[i], last_m));
        hold(lc_ns[i], lc_ew[i], lc_dur[i]);
        want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
        if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
        last_m = lc_dur[i];
      end
    end
  endtask

  task automatic test_conflict();
    expect_status("conflict_1clk", mk(0, 3'd0, P_EWY, 2, 5));
    expect_status("conflict_2clk", mk(1, 3'd2, P_FLT, 2, 5));
    bus.light_ns = G;
    bus.light_ew = G;
    cyc(1);
    bus.light_ns = R;
    bus.light_ew = Y;
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    cyc(1);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_clear_fault();
    expect_status("clear_to_all_red", mk(0, 3'd0, P_AR, 0, 0));
    clear_all_red();
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_sequence();
    expect_status("seq_green", mk(0, 3'd0, P_NSG, 5, 0));
    hold(G, R, 5);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("seq_skip_yellow", mk(1, 3'd3, P_FLT, 5, 0));
    bus.light_ns = R;
    bus.light_ew = R;
    cyc(2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("seq_clear", mk(0, 3'd0, P_AR, 0, 0));
    clear_all_red();
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_yellow_time();
    expect_status("ylw_green", mk(0, 3'd0, P_NSG, 5, 0));
    hold(G, R, 5);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("ylw_long", mk(0, 3'd0, P_NSY, 3, 5));
    hold(Y, R, 3);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("ylw_fault", mk(1, 3'd4, P_FLT, 3, 5));
    bus.light_ns = R;
    bus.light_ew = G;
    cyc(2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("ylw_clear", mk(0, 3'd0, P_AR, 0, 0));
    clear_all_red();
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_short_green();
    expect_status("short_green_run", mk(0, 3'd0, P_EWG, 4, 0));
    hold(R, G, 4);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("short_green_fault", mk(1, 3'd5, P_FLT, 4, 0));
    bus.light_ns = R;
    bus.light_ew = Y;
    cyc(2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("short_green_clear", mk(0, 3'd0, P_AR, 0, 0));
    clear_all_red();
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_timeout();
    expect_status("timeout_at_max", mk(0, 3'd0, P_AR, 30, 0));
    hold(R, R, 30);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("timeout_fault", mk(1, 3'd6, P_FLT, 31, 0));
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
    cyc(2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("timeout_clear", mk(0, 3'd0, P_AR, 0, 0));
    clear_all_red();
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_priority();
    expect_status("prio_green", mk(0, 3'd0, P_NSG, 5, 0));
    hold(G, R, 5);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("prio_enc_over_conflict", mk(1, 3'd1, P_FLT, 5, 0));
    bus.light_ns = 3'b011;
    bus.light_ew = G;
    cyc(2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("clear_vs_violation", mk(1, 3'd2, P_FLT, 5, 0));
    bus.light_ns    = G;
    bus.light_ew    = G;
    bus.clear_fault = 1'b1;
    cyc(1);
    bus.clear_fault = 1'b0;
    cyc(2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("prio_clear", mk(0, 3'd0, P_AR, 0, 0));
    clear_all_red();
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  task automatic test_reset_mid();
    expect_status("mid_green_3s", mk(0, 3'd0, P_NSG, 3, 0));
    hold(G, R, 3);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("async_reset", mk(0, 3'd0, P_SYNC, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    cyc(2);
    reset = 1'b0;
    expect_status("resync_adopt", mk(0, 3'd0, P_NSG, 0, 0));
    cyc(2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
    expect_status("resync_counting", mk(0, 3'd0, P_NSG, 2, 0));
    hold(G, R, 2);
    want = exp_q.pop_front(); nm = name_q.pop_front(); got = sample(); n_vec++;
    if (got !== want) begin n_err++; $display("FAIL %s: got %s, want %s", nm, fmt(got), fmt(want)); end
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_clear_fault();
    test_sequence();
    test_yellow_time();
    test_short_green();
    test_timeout();
    test_priority();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
